// File: rtl/reg_bus_reader.sv
// Register-bank read port: snapshots reg_values[rd_sel] and drives it on the shared bus for HOLD_CYCLES.
// Latency: ack 1 cycle after request, bus_oe 2 cycles after; requests arriving while busy are dropped, not queued.
module reg_bus_reader #(
   parameter int WIDTH       = 8,
   parameter int NUM_REGS    = 4,
   parameter int SEL_W       = 2,
   parameter int HOLD_CYCLES = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REGS*WIDTH-1:0] reg_values,
   input  logic                      rd_req,
   input  logic [SEL_W-1:0]          rd_sel,
   output logic                      rd_ack,
   output logic                      rd_err,
   output logic                      busy,
   output logic                      bus_oe,
   output logic [WIDTH-1:0]          bus_data
);

   localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
   // One extra bit so NUM_REGS == 2**SEL_W is still representable.
   localparam logic [SEL_W:0] NREGS = (SEL_W + 1)'(NUM_REGS);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DRIVE   = 2'd2
   } state_t;

   state_t           state;
   logic [SEL_W-1:0] sel_q;
   logic [CNT_W-1:0] cnt;
   logic             sel_ok;

   assign sel_ok = ({1'b0, rd_sel} < NREGS);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         sel_q    <= '0;
         cnt      <= '0;
         rd_ack   <= 1'b0;
         rd_err   <= 1'b0;
         busy     <= 1'b0;
         bus_oe   <= 1'b0;
         bus_data <= '0;
      end else begin
         rd_ack <= 1'b0;
         rd_err <= 1'b0;
         case (state)
            IDLE: begin
               if (rd_req) begin
                  if (sel_ok) begin
                     sel_q  <= rd_sel;
                     rd_ack <= 1'b1;
                     busy   <= 1'b1;
                     state  <= CAPTURE;
                  end else begin
                     rd_err <= 1'b1;
                  end
               end
            end
            CAPTURE: begin
               // Value is frozen here; later register updates do not reach the bus.
               bus_data <= reg_values[sel_q*WIDTH +: WIDTH];
               bus_oe   <= 1'b1;
               cnt      <= CNT_LOAD;
               state    <= DRIVE;
            end
            DRIVE: begin
               if (cnt == '0) begin
                  bus_oe   <= 1'b0;
                  bus_data <= '0;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               bus_oe   <= 1'b0;
               bus_data <= '0;
               busy     <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reg_bus_reader.sv
// Directed bench for reg_bus_reader: default, NUM_REGS=3 and HOLD_CYCLES=1 instances.
// Observed vector per cycle is {rd_ack, rd_err, busy, bus_oe, bus_data}.
module tb_reg_bus_reader;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Default instance
   logic [31:0] vals = '0;
   logic        req = 1'b0;
   logic [1:0]  sel = '0;
   logic        ack, err, bsy, oe;
   logic [7:0]  dat;

   // NUM_REGS = 3 instance
   logic [23:0] vals3 = '0;
   logic        req3 = 1'b0;
   logic [1:0]  sel3 = '0;
   logic        ack3, err3, bsy3, oe3;
   logic [7:0]  dat3;

   // HOLD_CYCLES = 1 instance
   logic [31:0] vals1 = '0;
   logic        req1 = 1'b0;
   logic [1:0]  sel1 = '0;
   logic        ack1, err1, bsy1, oe1;
   logic [7:0]  dat1;

   reg_bus_reader dut (
      .clk(clk), .rst(rst), .reg_values(vals), .rd_req(req), .rd_sel(sel),
      .rd_ack(ack), .rd_err(err), .busy(bsy), .bus_oe(oe), .bus_data(dat)
   );

   reg_bus_reader #(.NUM_REGS(3)) dut3 (
      .clk(clk), .rst(rst), .reg_values(vals3), .rd_req(req3), .rd_sel(sel3),
      .rd_ack(ack3), .rd_err(err3), .busy(bsy3), .bus_oe(oe3), .bus_data(dat3)
   );

   reg_bus_reader #(.HOLD_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst), .reg_values(vals1), .rd_req(req1), .rd_sel(sel1),
      .rd_ack(ack1), .rd_err(err1), .busy(bsy1), .bus_oe(oe1), .bus_data(dat1)
   );

   logic [11:0] obs, obs3, obs1;
   assign obs  = {ack,  err,  bsy,  oe,  dat};
   assign obs3 = {ack3, err3, bsy3, oe3, dat3};
   assign obs1 = {ack1, err1, bsy1, oe1, dat1};

   task automatic test_reset();
      logic [11:0] exp [1:4];
      exp = '{12'hA00, 12'h3E7, 12'h3E7, 12'h000};
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         tests++;
         if (obs !== 12'h000) begin
            fails++;
            $display("FAIL reset_hold cycle %0d: got %h expected 000", c, obs);
         end
      end
      tests++;
      if ({obs3, obs1} !== 24'h0) begin
         fails++;
         $display("FAIL reset_other_inst: got %h/%h expected 000/000", obs3, obs1);
      end
      rst = 1'b1;
      @(negedge clk);
      vals[31:24] = 8'hE7;
      req = 1'b1; sel = 2'd3;
      @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      tests++;
      if (obs !== 12'h3E7) begin
         fails++;
         $display("FAIL reset_pre_drive: got %h expected 3e7", obs);
      end
      #2 rst = 1'b0;
      #1;
      tests++;
      if (obs !== 12'h000) begin
         fails++;
         $display("FAIL reset_async_abort: got %h expected 000", obs);
      end
      @(negedge clk);
      tests++;
      if (obs !== 12'h000) begin
         fails++;
         $display("FAIL reset_abort_held: got %h expected 000", obs);
      end
      rst = 1'b1;
      @(negedge clk);
      tests++;
      if (obs !== 12'h000) begin
         fails++;
         $display("FAIL reset_idle_after: got %h expected 000", obs);
      end
      req = 1'b1; sel = 2'd3;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         req = 1'b0;
         tests++;
         if (obs !== exp[c]) begin
            fails++;
            $display("FAIL reset_clean_read cycle %0d: got %h expected %h", c, obs, exp[c]);
         end
      end
   endtask

   task automatic test_basic_read();
      logic [11:0] exp [1:4];
      exp = '{12'hA00, 12'h3A5, 12'h3A5, 12'h000};
      vals[23:16] = 8'hA5;
      req = 1'b1; sel = 2'd2;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         req = 1'b0;
         tests++;
         if (obs !== exp[c]) begin
            fails++;
            $display("FAIL basic_read cycle %0d: got %h expected %h", c, obs, exp[c]);
         end
      end
   endtask

   task automatic test_snapshot();
      logic [11:0] exp [1:4];
      exp = '{12'hA00, 12'h3A5, 12'h3A5, 12'h000};
      vals[23:16] = 8'hA5;
      req = 1'b1; sel = 2'd2;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         req = 1'b0;
         tests++;
         if (obs !== exp[c]) begin
            fails++;
            $display("FAIL snapshot cycle %0d: got %h expected %h", c, obs, exp[c]);
         end
         if (c == 2) vals[23:16] = 8'h3C;
      end
      vals[23:16] = 8'hA5;
   endtask

   task automatic test_busy_ignore();
      logic [11:0] exp [1:8];
      exp = '{12'hA00, 12'h3A5, 12'h3A5, 12'h000, 12'hA00, 12'h35A, 12'h35A, 12'h000};
      vals[15:8] = 8'h5A;
      req = 1'b1; sel = 2'd2;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         tests++;
         if (obs !== exp[c]) begin
            fails++;
            $display("FAIL busy_ignore cycle %0d: got %h expected %h", c, obs, exp[c]);
         end
         req = (c == 2 || c == 4);
         sel = 2'd1;
      end
      req = 1'b0;
   endtask

   task automatic test_invalid_sel();
      logic [11:0] exp [1:6];
      exp = '{12'h400, 12'h000, 12'hA00, 12'h3C3, 12'h3C3, 12'h000};
      vals3[7:0] = 8'hC3;
      req3 = 1'b1; sel3 = 2'd3;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         tests++;
         if (obs3 !== exp[c]) begin
            fails++;
            $display("FAIL invalid_sel cycle %0d: got %h expected %h", c, obs3, exp[c]);
         end
         req3 = (c == 2);
         sel3 = 2'd0;
      end
   endtask

   task automatic test_back_to_back();
      logic [11:0] exp [1:7];
      exp = '{12'hA00, 12'h396, 12'h000, 12'hA00, 12'h396, 12'h000, 12'h000};
      vals1[7:0] = 8'h96;
      req1 = 1'b1; sel1 = 2'd0;
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         tests++;
         if (obs1 !== exp[c]) begin
            fails++;
            $display("FAIL back_to_back cycle %0d: got %h expected %h", c, obs1, exp[c]);
         end
         if (c == 5) req1 = 1'b0;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_basic_read();
      test_snapshot();
      test_busy_ignore();
      test_invalid_sel();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
